// File: rtl/gate4_reduce_pipe_if.sv
// Handshake and result bus for gate4_reduce_pipe: vector in, reduced head entry and stats out.
interface gate4_reduce_pipe_if #(
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       out_data;
  logic             out_and;
  logic             out_or;
  logic             out_xor;
  logic [CNT_W-1:0] cnt_all;
  logic [CNT_W-1:0] cnt_odd;

  modport master (
    output in_valid, in, out_ready,
    input  in_ready, out_valid, out_data, out_and, out_or, out_xor, cnt_all, cnt_odd
  );

  modport slave (
    input  in_valid, in, out_ready,
    output in_ready, out_valid, out_data, out_and, out_or, out_xor, cnt_all, cnt_odd
  );
endinterface

// File: rtl/gate4_reduce_pipe.sv
// 4-bit AND/OR/XOR reduction into a small result FIFO with saturating push statistics.
module gate4_reduce_calc (
  input  logic [3:0] vec,
  output logic [6:0] ent
);
  assign ent = {vec, &vec, |vec, ^vec};
endmodule

module gate4_reduce_pipe #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  gate4_reduce_pipe_if.slave  bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [3:0] data;
    logic       r_and;
    logic       r_or;
    logic       r_xor;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          new_ent;
  entry_t          head;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic [CNT_W-1:0] cnt_all_q;
  logic [CNT_W-1:0] cnt_odd_q;
  logic            run_q;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;

  gate4_reduce_calc u_calc (
    .vec (bus.in),
    .ent (new_ent)
  );

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // run_q holds handshakes off for the first edge after reset release.
  assign push = run_q && !clr && bus.in_valid && !full;
  assign pop  = run_q && !clr && bus.out_ready && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run_q <= 1'b0;
    else        run_q <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= new_ent;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_all_q <= '0;
      cnt_odd_q <= '0;
    end else if (clr) begin
      cnt_all_q <= '0;
      cnt_odd_q <= '0;
    end else if (push) begin
      if (cnt_all_q != {CNT_W{1'b1}})                 cnt_all_q <= cnt_all_q + 1'b1;
      if (new_ent.r_xor && cnt_odd_q != {CNT_W{1'b1}}) cnt_odd_q <= cnt_odd_q + 1'b1;
    end
  end

  // Head is always read from storage so idle outputs stay defined.
  assign head          = mem[rd_ptr];
  assign bus.in_ready  = !full;
  assign bus.out_valid = !empty;
  assign bus.out_data  = head.data;
  assign bus.out_and   = head.r_and;
  assign bus.out_or    = head.r_or;
  assign bus.out_xor   = head.r_xor;
  assign bus.cnt_all   = cnt_all_q;
  assign bus.cnt_odd   = cnt_odd_q;
endmodule

// File: tb/tb_gate4_reduce_pipe.sv
// Scoreboard bench for gate4_reduce_pipe with DEPTH=4, CNT_W=3.
module tb_gate4_reduce_pipe;
  localparam int DEPTH   = 4;
  localparam int CNT_W   = 3;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk;
  logic rst_n;
  logic clr;

  gate4_reduce_pipe_if #(.CNT_W(CNT_W)) bus ();

  gate4_reduce_pipe #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int         checks   = 0;
  int         failures = 0;
  logic [6:0] sb_q [$];
  int         m_all    = 0;
  int         m_odd    = 0;
  bit         first_edge = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] ent(input logic [3:0] d);
    return {d, &d, |d, ^d};
  endfunction

  task automatic check_state(input string tag);
    check({tag, ".in_ready"},  32'(bus.in_ready),  32'(sb_q.size() < DEPTH));
    check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(sb_q.size() != 0));
    check({tag, ".cnt_all"},   32'(bus.cnt_all),   32'(m_all));
    check({tag, ".cnt_odd"},   32'(bus.cnt_odd),   32'(m_odd));
    if (sb_q.size() != 0)
      check({tag, ".head"}, 32'({bus.out_data, bus.out_and, bus.out_or, bus.out_xor}), 32'(sb_q[0]));
  endtask

  // One clock: drive, let the edge happen, update the model, then check at negedge.
  task automatic cyc(input logic v, input logic [3:0] d, input logic r, input logic c, input string tag);
    bit acc_push, acc_pop;
    bus.in_valid  = v;
    bus.in        = d;
    bus.out_ready = r;
    clr           = c;
    acc_push = v && !c && (sb_q.size() < DEPTH) && !first_edge;
    acc_pop  = r && !c && (sb_q.size() != 0)    && !first_edge;
    @(posedge clk);
    first_edge = 0;
    if (c) begin
      sb_q.delete();
      m_all = 0;
      m_odd = 0;
    end else begin
      if (acc_pop) void'(sb_q.pop_front());
      if (acc_push) begin
        sb_q.push_back(ent(d));
        if (m_all < CNT_MAX) m_all++;
        if (^d && m_odd < CNT_MAX) m_odd++;
      end
    end
    @(negedge clk);
    check_state(tag);
  endtask

  logic [3:0] pass_vec [7] = '{4'b0000, 4'b0001, 4'b1111, 4'b1010, 4'b0101, 4'b1001, 4'b0011};
  logic [2:0] pass_exp [7] = '{3'b000, 3'b011, 3'b110, 3'b010, 3'b010, 3'b010, 3'b010};
  logic [3:0] fill_vec [4] = '{4'b1111, 4'b0001, 4'b1010, 4'b0111};

  initial begin
    rst_n = 1'b0;
    clr   = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in        = 4'b0;
    bus.out_ready = 1'b0;
    #7;
    check("rst.out_valid", 32'(bus.out_valid), 0);
    check("rst.in_ready",  32'(bus.in_ready),  1);
    check("rst.out_data",  32'(bus.out_data),  0);
    check("rst.flags",     32'({bus.out_and, bus.out_or, bus.out_xor}), 0);
    check("rst.cnt_all",   32'(bus.cnt_all),   0);
    check("rst.cnt_odd",   32'(bus.cnt_odd),   0);
    @(negedge clk);
    rst_n = 1'b1;
    first_edge = 1;
    cyc(0, 4'b0, 0, 0, "settle");

    // Single pass with out_ready high
    for (int i = 0; i < 7; i++) begin
      cyc(1, pass_vec[i], 1, 0, "pass");
      check("pass.flags", 32'({bus.out_and, bus.out_or, bus.out_xor}), 32'(pass_exp[i]));
      check("pass.data",  32'(bus.out_data), 32'(pass_vec[i]));
    end
    cyc(0, 4'b0, 1, 0, "pass_drain");
    check("pass.cnt_all", 32'(bus.cnt_all), 7);
    check("pass.cnt_odd", 32'(bus.cnt_odd), 1);

    // Fill and backpressure
    cyc(0, 4'b0, 0, 1, "clr0");
    for (int i = 0; i < 4; i++) cyc(1, fill_vec[i], 0, 0, "fill");
    check("fill.in_ready", 32'(bus.in_ready), 0);
    cyc(1, 4'b0100, 0, 0, "held");
    check("held.out_data", 32'(bus.out_data), 32'(4'b1111));
    check("held.in_ready", 32'(bus.in_ready), 0);

    // Pop from full, then steady push+pop
    cyc(1, 4'b0100, 1, 0, "pop_full");
    check("pop_full.in_ready", 32'(bus.in_ready), 1);
    check("pop_full.head",     32'(bus.out_data), 32'(4'b0001));
    for (int i = 0; i < 4; i++) begin
      cyc(1, 4'(4'b1000 + i), 1, 0, "steady");
      check("steady.in_ready", 32'(bus.in_ready), 1);
    end

    // Counter saturation
    cyc(0, 4'b0, 0, 1, "clr1");
    for (int i = 0; i < 10; i++) cyc(1, 4'b0001, 1, 0, "sat");
    cyc(0, 4'b0, 1, 0, "sat_drain");
    check("sat.cnt_all", 32'(bus.cnt_all), 7);
    check("sat.cnt_odd", 32'(bus.cnt_odd), 7);

    // clr wins over a same-cycle push
    cyc(0, 4'b0, 0, 1, "clr2");
    cyc(1, 4'b0011, 0, 0, "pre_clr");
    cyc(1, 4'b0110, 0, 0, "pre_clr");
    cyc(1, 4'b1000, 0, 1, "clr_push");
    check("clr_push.out_valid", 32'(bus.out_valid), 0);
    check("clr_push.cnt_all",   32'(bus.cnt_all),   0);
    cyc(0, 4'b0, 1, 0, "post_clr");
    check("post_clr.out_valid", 32'(bus.out_valid), 0);

    // Async reset mid-stream
    cyc(1, 4'b0111, 0, 0, "pre_rst");
    cyc(1, 4'b1011, 0, 0, "pre_rst");
    cyc(1, 4'b1101, 0, 0, "pre_rst");
    #2 rst_n = 1'b0;
    #1;
    sb_q.delete();
    m_all = 0;
    m_odd = 0;
    check("arst.out_valid", 32'(bus.out_valid), 0);
    check("arst.in_ready",  32'(bus.in_ready),  1);
    check("arst.cnt_all",   32'(bus.cnt_all),   0);
    check("arst.cnt_odd",   32'(bus.cnt_odd),   0);
    check("arst.out_data",  32'(bus.out_data),  0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    first_edge = 1;
    cyc(1, 4'b1111, 0, 0, "rel_edge");
    check("rel_edge.out_valid", 32'(bus.out_valid), 0);
    cyc(1, 4'b0110, 0, 0, "post_rst");
    check("post_rst.out_data", 32'(bus.out_data), 32'(4'b0110));
    check("post_rst.flags",    32'({bus.out_and, bus.out_or, bus.out_xor}), 32'(3'b010));
    cyc(0, 4'b0, 1, 0, "final_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/gate4_reduce_pipe.md
GATE4_REDUCE_PIPE -- requirements
Module: gate4_reduce_pipe

Interface
REQ-001 Parameter DEPTH, default 4: result buffer entries; power of two, 2..16.
REQ-002 Parameter CNT_W, default 8: width of both statistics counters.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 clr  input  1  synchronous flush of buffer and counters.
REQ-006 in_valid  input  1  upstream presents a vector on in.
REQ-007 in_ready  output  1  block can accept a vector this cycle.
REQ-008 in  input  4  operand vector.
REQ-009 out_valid  output  1  head buffer entry is valid.
REQ-010 out_ready  input  1  downstream consumes the head entry this cycle.
REQ-011 out_data  output  4  operand vector of the head entry.
REQ-012 out_and  output  1  4-input AND of out_data.
REQ-013 out_or  output  1  4-input OR of out_data.
REQ-014 out_xor  output  1  4-input XOR (odd parity) of out_data.
REQ-015 cnt_all  output  CNT_W  accepted-vector count.
REQ-016 cnt_odd  output  CNT_W  count of accepted vectors with XOR = 1.

Function
REQ-017 Push occurs when in_valid && in_ready at a rising edge; the entry {in, &in, |in, ^in} is computed and written into the buffer on that edge.
REQ-018 in_ready SHALL be !full, derived from registered state only, with no combinational path from out_ready or in_valid.
REQ-019 Pop occurs when out_valid && out_ready at a rising edge; the read pointer advances to the next entry.
REQ-020 out_valid SHALL be !empty; out_data, out_and, out_or and out_xor SHALL reflect the head entry and hold stable while out_valid && !out_ready.
REQ-021 Latency: a vector pushed at edge N SHALL appear at the outputs after edge N when the buffer was empty (1-cycle latency).
REQ-022 Ordering is strict FIFO, and no accepted entry is ever dropped or duplicated.
REQ-023 Simultaneous push and pop with the buffer non-empty and not full SHALL leave the occupancy unchanged.
REQ-024 When full, in_ready = 0 and a pop in that cycle does not allow a same-cycle push; in_ready rises on the following cycle.
REQ-025 Pointers SHALL wrap modulo DEPTH; occupancy uses a log2(DEPTH)+1-bit count, with full when count == DEPTH and empty when count == 0.
REQ-026 cnt_all SHALL increment by 1 on every push and saturate at 2^CNT_W-1.
REQ-027 cnt_odd SHALL increment by 1 on every push whose ^in = 1 and saturate at 2^CNT_W-1.
REQ-028 clr = 1 SHALL empty the buffer, zero both counters, and block push and pop in that cycle; clr has priority over both.
REQ-029 Outputs with out_valid = 0 are don't-care for the consumer, but the RTL SHALL drive them from buffer storage (no X propagation after reset).

Reset
REQ-030 rst_n = 0 SHALL immediately clear the pointers, occupancy, cnt_all, cnt_odd and all buffer storage to 0, regardless of clk.
REQ-031 During and after reset: out_valid = 0, in_ready = 1, out_data = 4'b0000, out_and = 0, out_or = 0, out_xor = 0, cnt_all = 0, cnt_odd = 0.
REQ-032 Reset asserted mid-operation SHALL discard all buffered entries; the first push after release behaves as into an empty buffer.
REQ-033 Release of rst_n SHALL be synchronised internally so that no push or pop occurs on the first edge after deassertion.

Verification
REQ-034 Single pass: push 0000, 0001, 1111, 1010, 0101, 1001, 0011 with out_ready = 1 -> outputs (and,or,xor) = 000, 011, 110, 010, 010, 010, 010 one cycle after each push; cnt_all = 7, cnt_odd = 1.
REQ-035 Fill/backpressure, DEPTH = 4, out_ready = 0: push 1111, 0001, 1010, 0111 -> in_ready = 0 after the 4th push, a 5th vector is held upstream, and out_data holds 1111.
REQ-036 Drain with simultaneous traffic: from full, raise out_ready for 1 cycle -> pop 1111, occupancy 3, in_ready = 1 the next cycle; then push+pop every cycle -> occupancy stays 3, order preserved.
REQ-037 Saturation, CNT_W = 3: push 0001 ten times -> cnt_all = 7 and cnt_odd = 7, both holding.
REQ-038 clr with push: clr = 1 in the same cycle as in_valid = 1 and in = 1000 with 2 entries buffered -> next cycle out_valid = 0, counters = 0, and 1000 is not stored.
REQ-039 Async reset mid-stream: drop rst_n between clock edges with 3 entries buffered -> out_valid = 0 and counters = 0 before the next edge; after release, push 0110 -> out_data = 0110, (and,or,xor) = 010.
